fifo_wr_adapter: RTL



---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_skid_buf.sv | 95 +++++++++
 rtl/fifo_wr_adapter.sv | 73 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO: buffer state encoding and
// Gray-code conversion reused by both pointer domains.
package fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    localparam int GRAY_W_MAX = 32;

    // Width-agnostic: callers zero-extend a narrower Gray value and cast the
    // result back, since leading zeros convert to leading zeros.
    function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] gray);
        logic [GRAY_W_MAX-1:0] bin;
        bin = gray;
        for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer between the upstream valid/ready stream and the FIFO
// write port; s_ready is registered so wfull never reaches it combinationally.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DSIZE-1:0] s_data,
    output logic             winc,
    output logic [DSIZE-1:0] wdata,
    input  logic             wfull
);

    buf_state_e       state_r;
    buf_state_e       state_next_s;
    logic [DSIZE-1:0] head_r;
    logic [DSIZE-1:0] head_next_s;
    logic [DSIZE-1:0] tail_r;
    logic [DSIZE-1:0] tail_next_s;
    logic             s_ready_r;
    logic             winc_r;
    logic             in_xfer_s;
    logic             out_xfer_s;

    assign in_xfer_s  = s_valid & s_ready_r;
    assign out_xfer_s = winc_r & ~wfull;

    // Next-state and storage update for the head/tail entries.
    always_comb begin
        state_next_s = state_r;
        head_next_s  = head_r;
        tail_next_s  = tail_r;
        case (state_r)
            EMPTY: begin
                if (in_xfer_s) begin
                    state_next_s = ONE;
                    head_next_s  = s_data;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            ONE: begin
                if (in_xfer_s && !out_xfer_s) begin
                    state_next_s = TWO;
                    tail_next_s  = s_data;
                end else if (out_xfer_s && !in_xfer_s) begin
                    state_next_s = EMPTY;
                end else if (out_xfer_s && in_xfer_s) begin
                    state_next_s = ONE;
                    head_next_s  = s_data;
                end else begin
                    state_next_s = ONE;
                end
            end
            TWO: begin
                // s_ready is low here, so only a drain can happen.
                if (out_xfer_s) begin
                    state_next_s = ONE;
                    head_next_s  = tail_r;
                end else begin
                    state_next_s = TWO;
                end
            end
            default: begin
                state_next_s = EMPTY;
            end
        endcase
    end

    // State, storage and registered handshake outputs.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_r   <= EMPTY;
            head_r    <= {DSIZE{1'b0}};
            tail_r    <= {DSIZE{1'b0}};
            s_ready_r <= 1'b0;
            winc_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            head_r    <= head_next_s;
            tail_r    <= tail_next_s;
            s_ready_r <= (state_next_s != TWO);
            winc_r    <= (state_next_s != EMPTY);
        end
    end

    assign s_ready = s_ready_r;
    assign winc    = winc_r;
    assign wdata   = head_r;

endmodule

// File: rtl/fifo_wr_adapter.sv
// Write-side front end of the async FIFO: skid-buffered stream input plus
// pessimistic write-domain occupancy and a programmable almost-full flag.
module fifo_wr_adapter
    import fifo_pkg::*;
#(
    parameter int DSIZE        = 8,
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = (32'sd1 <<< ADDRSIZE) - 32'sd2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DSIZE-1:0]    s_data,
    output logic                winc,
    output logic [DSIZE-1:0]    wdata,
    input  logic                wfull,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                awfull
);

    localparam int              PTR_W  = ADDRSIZE + 1;
    localparam logic [PTR_W-1:0] THRESH = PTR_W'(AFULL_THRESH);

    logic             winc_s;
    logic             out_xfer_s;
    logic [PTR_W-1:0] wcnt_r;
    logic [PTR_W-1:0] wcnt_next_s;
    logic [PTR_W-1:0] rbin_s;
    logic [PTR_W-1:0] level_next_s;
    logic [PTR_W-1:0] wlevel_r;
    logic             awfull_r;

    fifo_skid_buf #(
        .DSIZE (DSIZE)
    ) u_skid (
        .wclk    (wclk),
        .wrst    (wrst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .winc    (winc_s),
        .wdata   (wdata),
        .wfull   (wfull)
    );

    assign winc       = winc_s;
    assign out_xfer_s = winc_s & ~wfull;

    // The count mirrors the FIFO's binary write pointer, so the same modulo
    // subtraction against the synchronized read pointer gives the level.
    assign wcnt_next_s  = wcnt_r + {{ADDRSIZE{1'b0}}, out_xfer_s};
    assign rbin_s       = PTR_W'(gray2bin(GRAY_W_MAX'(wq2_rptr)));
    assign level_next_s = wcnt_next_s - rbin_s;

    // Write count, level and almost-full, all updated on the same edge.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wcnt_r   <= {PTR_W{1'b0}};
            wlevel_r <= {PTR_W{1'b0}};
            awfull_r <= 1'b0;
        end else begin
            wcnt_r   <= wcnt_next_s;
            wlevel_r <= level_next_s;
            awfull_r <= (level_next_s >= THRESH);
        end
    end

    assign wlevel = wlevel_r;
    assign awfull = awfull_r;

endmodule
